imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction fetch controller with prefetch FIFO and redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    ERR   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     issue_pc_q, issue_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic            fetch_err_q, fetch_err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     pc_mem_q [FIFO_DEPTH];
  logic [31:0]     pc_mem_d [FIFO_DEPTH];
  logic [31:0]     instr_mem_q [FIFO_DEPTH];
  logic [31:0]     instr_mem_d [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic [CW:0]     used;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + PW'(1);
    end
  endfunction

  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign fetch_err = fetch_err_q;
  assign mem_addr  = fetch_pc_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issue_pc_d  = issue_pc_q;
    inflight_d  = 1'b0;
    kill_d      = 1'b0;
    fetch_err_d = fetch_err_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    mem_req     = 1'b0;

    pop  = out_valid && out_ready;
    // A slot freed by this cycle's pop is reusable now, sustaining one word per cycle.
    used = {1'b0, count_q} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight_q};
    push = (state_q == FETCH) && inflight_q && !kill_q;

    if ((state_q == FETCH) && !redirect_valid && !rst &&
        (used < (CW+1)'(FIFO_DEPTH))) begin
      mem_req = 1'b1;
    end

    if (mem_req) begin
      inflight_d = 1'b1;
      issue_pc_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (push) begin
      pc_mem_d[wr_ptr_q]    = issue_pc_q;
      instr_mem_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d              = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    // Redirect flushes everything, including a response arriving this cycle.
    if (redirect_valid) begin
      kill_d     = 1'b1;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d     = ERR;
        fetch_err_d = 1'b1;
      end else begin
        state_d     = FETCH;
        fetch_err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      issue_pc_q  <= RESET_PC;
      inflight_q  <= 1'b0;
      kill_q      <= 1'b0;
      fetch_err_q <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issue_pc_q  <= issue_pc_d;
      inflight_q  <= inflight_d;
      kill_q      <= kill_d;
      fetch_err_q <= fetch_err_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Payload storage is masked at the outputs while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Scoreboard bench for imem_fetch_ctrl with an address-tagged memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    tag = a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) mem_rdata <= mem_req ? tag(mem_addr) : 32'hDEAD_BEEF;

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err got=%b exp=0", fetch_err); end
  endtask

  task automatic test_stream();
    int popped = 0;
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
      if (c == 0) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
          errors++; $display("FAIL stream_first_req got=%b/%h exp=1/00000000", mem_req, mem_addr);
        end
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_continuous c=%0d got=%b exp=1", c, out_valid); end
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); popped++; checks++;
        if (out_pc !== e || out_instr !== tag(e)) begin
          errors++; $display("FAIL stream_data got=%h/%h exp=%h/%h", out_pc, out_instr, e, tag(e));
        end
      end
    end
    checks++; if (popped != 10) begin errors++; $display("FAIL stream_count got=%0d exp=10", popped); end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    int popped = 0;
    logic [31:0] e;
    @(negedge clk); rst = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); rst = 1'b0; out_ready = 1'b0; #1;
      if (mem_req) begin
        checks++;
        if (mem_addr !== 32'(nreq * 4)) begin
          errors++; $display("FAIL bp_req_addr got=%h exp=%h", mem_addr, 32'(nreq * 4));
        end
        nreq++;
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
          errors++; $display("FAIL bp_hold got=%b/%h exp=1/00000000", out_valid, out_pc);
        end
      end
    end
    checks++; if (nreq != 2) begin errors++; $display("FAIL bp_req_count got=%0d exp=2", nreq); end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); popped++; checks++;
        if (out_pc !== e || out_instr !== tag(e)) begin
          errors++; $display("FAIL bp_data got=%h/%h exp=%h/%h", out_pc, out_instr, e, tag(e));
        end
      end
    end
    checks++; if (popped != 6) begin errors++; $display("FAIL bp_drain_count got=%0d exp=6", popped); end
  endtask

  task automatic test_redirect_full();
    int popped = 0;
    logic [31:0] e;
    @(negedge clk); rst = 1'b1; out_ready = 1'b0;
    repeat (2) begin @(negedge clk); rst = 1'b0; out_ready = 1'b0; end
    exp_q.delete();
    exp_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    for (int c = 2; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      redirect_valid = (c == 2);
      redirect_pc = 32'h100;
      #1;
      if (c == 2) begin
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL redir_req_suppressed got=%b exp=0", mem_req); end
      end
      if (c == 3) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
          errors++; $display("FAIL redir_first_req got=%b/%h exp=1/00000100", mem_req, mem_addr);
        end
      end
      if (c == 3 || c == 4) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flushed c=%0d got=%b exp=0", c, out_valid); end
      end
      if (c == 5) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_latency got=%b exp=1", out_valid); end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++; $display("FAIL redir_extra got=%h exp=none", out_pc);
        end else begin
          e = exp_q.pop_front(); popped++; checks++;
          if (out_pc !== e || out_instr !== tag(e)) begin
            errors++; $display("FAIL redir_data got=%h/%h exp=%h/%h", out_pc, out_instr, e, tag(e));
          end
        end
      end
    end
    redirect_valid = 1'b0;
    checks++; if (popped != 6) begin errors++; $display("FAIL redir_count got=%0d exp=6", popped); end
  endtask

  task automatic test_misaligned();
    int popped = 0;
    logic [31:0] e;
    @(negedge clk); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
    for (int c = 1; c < 7; c++) begin
      @(negedge clk); redirect_valid = 1'b0; out_ready = 1'b1; #1;
      checks++;
      if (fetch_err !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL err_state c=%0d got=%b/%b/%b exp=1/0/0", c, fetch_err, mem_req, out_valid);
      end
    end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL err_exit_req got=%b exp=0", mem_req); end
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + 32'(i * 4));
    for (int c = 8; c < 13; c++) begin
      @(negedge clk); redirect_valid = 1'b0; out_ready = 1'b1; #1;
      if (c == 8) begin
        checks++;
        if (fetch_err !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin
          errors++; $display("FAIL err_recover got=%b/%b/%h exp=0/1/00000200", fetch_err, mem_req, mem_addr);
        end
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); popped++; checks++;
        if (out_pc !== e || out_instr !== tag(e)) begin
          errors++; $display("FAIL err_data got=%h/%h exp=%h/%h", out_pc, out_instr, e, tag(e));
        end
      end
    end
    checks++; if (popped != 3) begin errors++; $display("FAIL err_count got=%0d exp=3", popped); end
  endtask

  task automatic test_wrap();
    int popped = 0;
    logic [31:0] e;
    @(negedge clk); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
    for (int c = 1; c < 7; c++) begin
      @(negedge clk); redirect_valid = 1'b0; out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); popped++; checks++;
        if (out_pc !== e || out_instr !== tag(e)) begin
          errors++; $display("FAIL wrap_data got=%h/%h exp=%h/%h", out_pc, out_instr, e, tag(e));
        end
      end
    end
    checks++; if (popped != 4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", popped); end
  endtask

  task automatic test_mid_reset();
    int popped = 0;
    logic [31:0] e;
    @(negedge clk); rst = 1'b1; out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 19; c++) begin
      @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); popped++; checks++;
        if (out_pc !== e || out_instr !== tag(e)) begin
          errors++; $display("FAIL midrst_pre got=%h/%h exp=%h/%h", out_pc, out_instr, e, tag(e));
        end
      end
    end
    checks++; if (popped != 17) begin errors++; $display("FAIL midrst_pre_count got=%0d exp=17", popped); end
    @(negedge clk); rst = 1'b1; out_ready = 1'b0; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req got=%b exp=0", mem_req); end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL midrst_restart got=%b/%b/%h exp=0/1/00000000", out_valid, mem_req, mem_addr);
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    popped = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); popped++; checks++;
        if (out_pc !== e || out_instr !== tag(e)) begin
          errors++; $display("FAIL midrst_post got=%h/%h exp=%h/%h", out_pc, out_instr, e, tag(e));
        end
      end
    end
    checks++; if (popped != 3) begin errors++; $display("FAIL midrst_post_count got=%0d exp=3", popped); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
